// File: rtl/bcd_seg_counter.sv
// Prescaled up/down BCD counter with synchronous clear/load and a
// per-digit seven-segment decode with optional leading-zero blanking.
module bcd_seg_counter #(
    parameter int unsigned DIGITS         = 2,
    parameter int unsigned PRESCALE       = 50000000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          BLANK_LZ       = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  tick,
    output logic                  carry
);

    localparam int unsigned PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0]       pcnt;
    logic                pend;
    logic [4*DIGITS-1:0] inc_val;
    logic [4*DIGITS-1:0] dec_val;
    logic [4*DIGITS-1:0] ld_val;
    logic                inc_wrap;
    logic                dec_wrap;

    assign pend = (pcnt == PMAX);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] c;
        case (d)
            4'd0:    c = 7'h3F;
            4'd1:    c = 7'h06;
            4'd2:    c = 7'h5B;
            4'd3:    c = 7'h4F;
            4'd4:    c = 7'h66;
            4'd5:    c = 7'h6D;
            4'd6:    c = 7'h7D;
            4'd7:    c = 7'h07;
            4'd8:    c = 7'h7F;
            4'd9:    c = 7'h6F;
            default: c = 7'h00;
        endcase
        return c;
    endfunction

    // Ripple increment/decrement; the final carry/borrow out marks a full wrap.
    always_comb begin
        logic       ci;
        logic       bi;
        logic [3:0] d;
        inc_val = '0;
        dec_val = '0;
        ld_val  = '0;
        ci      = 1'b1;
        bi      = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            d = bcd[4*i +: 4];
            if (ci) begin
                if (d >= 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = d + 4'd1;
                    ci = 1'b0;
                end
            end else begin
                inc_val[4*i +: 4] = d;
            end
            if (bi) begin
                if (d == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = d - 4'd1;
                    bi = 1'b0;
                end
            end else begin
                dec_val[4*i +: 4] = d;
            end
            d = load_val[4*i +: 4];
            ld_val[4*i +: 4] = (d > 4'd9) ? 4'd0 : d;
        end
        inc_wrap = ci;
        dec_wrap = bi;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt  <= '0;
            bcd   <= '0;
            tick  <= 1'b0;
            carry <= 1'b0;
        end else if (clear) begin
            pcnt  <= '0;
            bcd   <= '0;
            tick  <= 1'b0;
            carry <= 1'b0;
        end else begin
            pcnt <= pend ? '0 : pcnt + 1'b1;
            tick <= pend;
            if (load) begin
                bcd   <= ld_val;
                carry <= 1'b0;
            end else if (en && pend) begin
                bcd   <= up ? inc_val : dec_val;
                carry <= up ? inc_wrap : dec_wrap;
            end else begin
                carry <= 1'b0;
            end
        end
    end

    // Scan from the most significant digit; blanking stops at the first nonzero digit.
    always_comb begin
        logic        lead;
        logic [3:0]  d;
        logic [6:0]  code;
        int unsigned i;
        seg  = '0;
        lead = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            i    = DIGITS - 1 - k;
            d    = bcd[4*i +: 4];
            code = seg7(d);
            if (BLANK_LZ && lead && (d == 4'd0) && (i != 0))
                code = 7'h00;
            if (d != 4'd0)
                lead = 1'b0;
            seg[7*i +: 7] = SEG_ACTIVE_LOW ? ~code : code;
        end
    end

endmodule

// File: tb/tb_bcd_seg_counter.sv
// Directed bench for bcd_seg_counter: a 2-digit prescaled instance and a
// 3-digit blanking instance with PRESCALE=1.
module tb_bcd_seg_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, up, clear, load;
    logic [7:0]  load_val;
    logic [7:0]  bcd;
    logic [13:0] seg;
    logic        tick, carry;

    logic        en1, up1, clear1, load1;
    logic [11:0] lv1;
    logic [11:0] bcd1;
    logic [20:0] seg1;
    logic        tick1, carry1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_seg_counter #(
        .DIGITS(2), .PRESCALE(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)
    ) u0 (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .bcd(bcd), .seg(seg), .tick(tick), .carry(carry)
    );

    bcd_seg_counter #(
        .DIGITS(3), .PRESCALE(1), .SEG_ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1)
    ) u1 (
        .clk(clk), .reset(reset), .en(en1), .up(up1), .clear(clear1), .load(load1),
        .load_val(lv1), .bcd(bcd1), .seg(seg1), .tick(tick1), .carry(carry1)
    );

    function automatic logic [6:0] code(input int d);
        logic [6:0] t [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return t[d];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        do begin
            cyc();
            n++;
        end while (!tick && n < 8);
        check(tag, 32'(tick), 32'd1);
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        cyc();
        load     = 1'b0;
    endtask

    task automatic do_load1(input logic [11:0] v);
        load1 = 1'b1;
        lv1   = v;
        cyc();
        load1 = 1'b0;
    endtask

    initial begin
        int c;
        reset = 1'b1;
        en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
        en1 = 1'b0; up1 = 1'b1; clear1 = 1'b0; load1 = 1'b0; lv1 = '0;
        #2;
        check("rst_bcd",   32'(bcd),   32'h00);
        check("rst_tick",  32'(tick),  32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_seg",   32'(seg),   32'h2040);
        en = 1'b1;
        #20 reset = 1'b0;

        // Scenario 1: count up from 00 to 10, tick every 4th cycle
        for (int k = 1; k <= 40; k++) begin
            cyc();
            c = k / 4;
            check("s1_bcd",   32'(bcd),   32'((c / 10) * 16 + (c % 10)));
            check("s1_tick",  32'(tick),  32'((k % 4) == 0));
            check("s1_carry", 32'(carry), 32'd0);
            if (k % 4 == 0)
                check("s1_seg", 32'(seg), 32'({~code(c / 10), ~code(c % 10)}));
        end

        // Scenario 2: up wrap 98 -> 99 -> 00 (carry) -> 01
        do_load(8'h98);
        check("s2_load", 32'(bcd), 32'h98);
        wait_tick("s2_t1");
        check("s2_99",   32'(bcd),   32'h99);
        check("s2_c99",  32'(carry), 32'd0);
        wait_tick("s2_t2");
        check("s2_00",   32'(bcd),   32'h00);
        check("s2_c00",  32'(carry), 32'd1);
        cyc();
        check("s2_cpulse", 32'(carry), 32'd0);
        wait_tick("s2_t3");
        check("s2_01",   32'(bcd),   32'h01);
        check("s2_c01",  32'(carry), 32'd0);

        // Scenario 3: down wrap 01 -> 00 -> 99 (carry) -> 98
        up = 1'b0;
        do_load(8'h01);
        wait_tick("s3_t1");
        check("s3_00",   32'(bcd),   32'h00);
        check("s3_c00",  32'(carry), 32'd0);
        wait_tick("s3_t2");
        check("s3_99",   32'(bcd),   32'h99);
        check("s3_c99",  32'(carry), 32'd1);
        wait_tick("s3_t3");
        check("s3_98",   32'(bcd),   32'h98);
        check("s3_c98",  32'(carry), 32'd0);

        // Scenario 4: load sanitising, clear beats load and restarts prescaler
        en = 1'b0;
        do_load(8'hAF);
        check("s4_AF", 32'(bcd), 32'h00);
        do_load(8'h3C);
        check("s4_3C", 32'(bcd), 32'h30);
        do_load(8'h97);
        check("s4_97", 32'(bcd), 32'h97);
        wait_tick("s4_align");
        cyc(); cyc(); cyc();
        clear = 1'b1; load = 1'b1; load_val = 8'h55;
        cyc();
        clear = 1'b0; load = 1'b0;
        check("s4_clr_bcd",   32'(bcd),   32'h00);
        check("s4_clr_tick",  32'(tick),  32'd0);
        check("s4_clr_carry", 32'(carry), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("s4_tick", 32'(tick), 32'(k == 4));
        end
        check("s4_hold", 32'(bcd), 32'h00);

        // Scenario 6: reset pulse mid-period abandons the pending step
        do_load(8'h42);
        check("s6_load", 32'(bcd), 32'h42);
        en = 1'b1; up = 1'b1;
        cyc();
        en = 1'b0;
        cyc();
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("s6_bcd",   32'(bcd),   32'h00);
        check("s6_seg",   32'(seg),   32'h2040);
        check("s6_tick",  32'(tick),  32'd0);
        check("s6_carry", 32'(carry), 32'd0);
        #9 reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            check("s6_ptick",  32'(tick),  32'(k == 4));
            check("s6_pcarry", 32'(carry), 32'd0);
            check("s6_pbcd",   32'(bcd),   32'h00);
        end

        // Scenario 5: 3 digits, blanking, active-high, PRESCALE=1
        check("s5_tick1", 32'(tick1), 32'd1);
        do_load1(12'h007);
        check("s5_seg007", 32'(seg1), 32'h000007);
        do_load1(12'h000);
        check("s5_seg000", 32'(seg1), 32'h00003F);
        do_load1(12'h100);
        check("s5_seg100", 32'(seg1), 32'h019FBF);
        do_load1(12'h020);
        check("s5_seg020", 32'(seg1), 32'h002DBF);
        do_load1(12'hFA3);
        check("s5_FA3", 32'(bcd1), 32'h003);
        en1 = 1'b1; up1 = 1'b1;
        do_load1(12'h999);
        check("s5_999", 32'(bcd1), 32'h999);
        cyc();
        en1 = 1'b0;
        check("s5_wrap",  32'(bcd1),   32'h000);
        check("s5_carry", 32'(carry1), 32'd1);
        cyc();
        check("s5_cpulse", 32'(carry1), 32'd0);
        clear1 = 1'b1;
        cyc();
        clear1 = 1'b0;
        check("s5_clr_tick", 32'(tick1), 32'd0);
        cyc();
        check("s5_tick_back", 32'(tick1), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
